// File: rtl/display_pkg.sv
// Shared types and 7-segment encodings for the result display path.
// Segment vectors are {g,f,e,d,c,b,a}, active-low (common-anode displays).
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Index k holds the pattern for decimal digit k.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Non-decimal nibble codes render blank rather than garbage.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        if (nib < 4'd10) s = SEG_TABLE[nib];
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, WIDTH cycles
// per conversion. bcd_out holds the last completed result and only changes
// when a conversion finishes, so it can drive a display directly.
// Handshake: start is accepted only while busy is low; busy is high for
// exactly WIDTH cycles; done pulses for one cycle with bcd_out valid.
// abort drops any conversion in flight and clears the result.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  last_step,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]           bin_sr;
    logic [DIGITS*4-1:0]        bcd_sr;
    logic [CW-1:0]              bit_cnt;
    logic [DIGITS*4-1:0]        bcd_adj;
    logic [DIGITS*4+WIDTH-1:0]  shifted;

    // One double-dabble iteration: correct each nibble, then shift left.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin_sr} << 1;
    end

    assign last_step = busy && (bit_cnt == CW'(WIDTH - 1));

    // Conversion sequencing and result latch.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                {bcd_sr, bin_sr} <= shifted;
                bit_cnt          <= bit_cnt + 1'b1;
                if (last_step) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    bcd_out <= shifted[DIGITS*4+WIDTH-1 -: DIGITS*4];
                end
            end else if (start) begin
                bin_sr  <= bin_in;
                bcd_sr  <= '0;
                bit_cnt <= '0;
                busy    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_display_control.sv
// Captures a signed product, converts its magnitude to BCD and scans sign plus
// DIGITS decimal digits onto multiplexed common-anode 7-segment displays.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digit slots above the
// most significant non-zero digit (slot 0 always shows a digit).
module result_display_control
    import display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              product_valid,
    input  logic [WIDTH-1:0]  product,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              negative,
    output logic [6:0]        seg,
    output logic [DIGITS:0]   an
);

    localparam int AW = DIGITS + 1;
    localparam int SW = $clog2(DIGITS + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t               state;
    logic                 start;
    logic                 last_step;
    logic                 have_result;
    logic [WIDTH-1:0]     magnitude;
    logic [DIGITS*4-1:0]  digits;
    logic [RW-1:0]        refresh_cnt;
    logic [SW-1:0]        slot_idx;
    logic [6:0]           digit_seg [DIGITS];
    logic [6:0]           slot_seg;

    // Products arriving mid-conversion are dropped; clear always wins.
    assign start     = product_valid && !clear && (state != ST_CONVERT);
    // Two's-complement negate; the most negative value wraps to 2^(WIDTH-1),
    // which is exactly its magnitude as an unsigned number.
    assign magnitude = product[WIDTH-1] ? (~product + 1'b1) : product;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk       (clk),
        .rst       (rst),
        .abort     (clear),
        .start     (start),
        .bin_in    (magnitude),
        .busy      (busy),
        .done      (done),
        .last_step (last_step),
        .bcd_out   (digits)
    );

    // Control FSM, sign capture and "result on display" flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= ST_IDLE;
            negative    <= 1'b0;
            have_result <= 1'b0;
        end else begin
            if (start) negative <= product[WIDTH-1];
            if (last_step) have_result <= 1'b1;
            case (state)
                ST_IDLE:    if (start) state <= ST_CONVERT;
                ST_CONVERT: if (last_step) state <= ST_SHOW;
                ST_SHOW:    if (start) state <= ST_CONVERT;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Scan timing: hold each slot REFRESH_DIV cycles, cycling 0..DIGITS.
    always_ff @(posedge clk) begin
        if (rst || clear || !have_result) begin
            refresh_cnt <= '0;
            slot_idx    <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            slot_idx    <= (slot_idx == SW'(DIGITS)) ? '0 : slot_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Per-digit segment patterns, optionally suppressing leading zeros.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic zero_run;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (digits[i*4 +: 4] == 4'd0);
            digit_seg[i] = (zero_run && (i != 0)) ? SEG_BLANK : bcd_to_seg(digits[i*4 +: 4]);
        end
`else
        for (int i = 0; i < DIGITS; i++) begin
            digit_seg[i] = bcd_to_seg(digits[i*4 +: 4]);
        end
`endif
    end

    // Pattern for the slot currently selected by the scan.
    always_comb begin
        slot_seg = SEG_BLANK;
        if (slot_idx == SW'(DIGITS)) begin
            slot_seg = negative ? SEG_MINUS : SEG_BLANK;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (slot_idx == SW'(i)) slot_seg = digit_seg[i];
            end
        end
    end

    // Registered display drive; dark until a result has been produced.
    always_ff @(posedge clk) begin
        if (rst || clear || !have_result) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= slot_seg;
            an  <= ~(AW'(1) << slot_idx);
        end
    end

endmodule

// File: tb/tb_result_display_control.sv
// Self-checking bench for result_display_control with a fast refresh divider.
module tb_result_display_control;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int RDIV   = 4;
  localparam int AW     = DIGITS + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              product_valid = 1'b0;
  logic [WIDTH-1:0]  product = '0;
  logic              clear = 1'b0;
  logic              busy, done, negative;
  logic [6:0]        seg;
  logic [DIGITS:0]   an;

  always #5 clk = ~clk;

  result_display_control #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .product_valid (product_valid),
    .product       (product),
    .clear         (clear),
    .busy          (busy),
    .done          (done),
    .negative      (negative),
    .seg           (seg),
    .an            (an)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int          m_busy_left = 0;
  bit          m_done = 0, m_neg = 0, m_disp_on = 0;
  int          m_shown = 0, m_pending = 0, m_slot = 0, m_ref = 0;
  logic [6:0]  m_seg = 7'h7F;
  logic [AW-1:0] m_an = '1;

  // Pattern a slot must show for the currently displayed value.
  function automatic logic [6:0] exp_slot_seg(input int slot);
    int p10 = 1;
    int d;
    if (slot == DIGITS) return m_neg ? 7'b0111111 : 7'h7F;
    for (int i = 0; i < slot; i++) p10 *= 10;
    d = (m_shown / p10) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot != 0 && m_shown < p10) return 7'h7F;
`endif
    return seg_tab[d];
  endfunction

  task automatic model_step();
    if (rst || clear) begin
      m_busy_left = 0; m_done = 0; m_neg = 0; m_shown = 0; m_disp_on = 0;
      m_slot = 0; m_ref = 0; m_seg = 7'h7F; m_an = '1;
    end else begin
      if (m_disp_on) begin
        m_an  = ~(AW'(1) << m_slot);
        m_seg = exp_slot_seg(m_slot);
        if (m_ref == RDIV - 1) begin
          m_ref  = 0;
          m_slot = (m_slot == DIGITS) ? 0 : m_slot + 1;
        end else begin
          m_ref++;
        end
      end else begin
        m_an = '1; m_seg = 7'h7F;
      end
      m_done = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_shown = m_pending; m_disp_on = 1; m_done = 1;
        end
      end else if (product_valid) begin
        m_neg       = product[WIDTH-1];
        m_pending   = product[WIDTH-1] ? (1 << WIDTH) - int'(product) : int'(product);
        m_busy_left = WIDTH;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("busy",     busy,     m_busy_left > 0);
      check("done",     done,     m_done);
      check("negative", negative, m_neg);
      check("seg",      seg,      m_seg);
      check("an",       an,       m_an);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [WIDTH-1:0] v);
    product = v; product_valid = 1'b1;
    @(negedge clk);
    product_valid = 1'b0; product = WIDTH'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done, 1);
  endtask

  logic [6:0] seen [AW];
  int         seen_done;

  task automatic scan_capture();
    for (int j = 0; j < AW; j++) seen[j] = 'x;
    seen_done = 0;
    repeat (AW * RDIV + 4) begin
      @(negedge clk);
      if (done) seen_done++;
      for (int j = 0; j < AW; j++) if (an == ~(AW'(1) << j)) seen[j] = seg;
    end
  endtask

  // exp[j] is the literal pattern slot j must show.
  task automatic check_slots(input string name, input logic [AW-1:0][6:0] exp);
    for (int j = 0; j < AW; j++) check($sformatf("%s_slot%0d", name, j), seen[j], exp[j]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] specials [10] = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99,
                                      16'd100, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFF6};

  initial begin
    int n;
    logic [6:0] top_1234, top_1111, mid_zero;
`ifdef LEADING_ZERO_BLANK_EN
    top_1234 = 7'h7F; top_1111 = 7'h7F; mid_zero = 7'h7F;
`else
    top_1234 = 7'h40; top_1111 = 7'h40; mid_zero = 7'h40;
`endif
    @(negedge clk);
    cmp_en = 1'b1;
    cyc(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_neg",  negative, 0);
    check("rst_seg",  seg, 7'h7F);
    check("rst_an",   an, 6'h3F);
    rst = 1'b0;
    cyc(2);

    // 1234: busy length, done latency, digits.
    pulse(16'd1234);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("p1234_busy_len", n, 16);
    check("p1234_done_at_17", done, 1);
    scan_capture();
    check_slots("p1234", {7'h7F, top_1234, 7'h79, 7'h24, 7'h30, 7'h19});
    check("p1234_neg", negative, 0);

    // Most negative value, recaptured from SHOW.
    pulse(16'h8000);
    wait_done("p32768");
    scan_capture();
    check_slots("p32768", {7'b0111111, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
    check("p32768_neg", negative, 1);

    // Zero.
    pulse(16'd0);
    wait_done("p0");
    scan_capture();
    check_slots("p0", {7'h7F, mid_zero, mid_zero, mid_zero, mid_zero, 7'h40});

    // A product arriving mid-conversion is dropped.
    pulse(16'd1111);
    cyc(4);
    pulse(16'd99);
    wait_done("p1111");
    scan_capture();
    check_slots("p1111", {7'h7F, top_1111, 7'h79, 7'h79, 7'h79, 7'h79});
    check("p1111_single_done", seen_done, 0);

    // Clear during conversion aborts it.
    pulse(16'd4321);
    cyc(3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_state", dut.state, display_pkg::ST_IDLE);
    check("clr_seg", seg, 7'h7F);
    check("clr_an", an, 6'h3F);
    check("clr_busy", busy, 0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n++;
    end
    check("clr_no_done", n, 0);

    // Reset while showing.
    pulse(16'hFB2E);
    wait_done("p_neg1234");
    cyc(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_show_state", dut.state, display_pkg::ST_IDLE);
    check("rst_show_seg", seg, 7'h7F);
    check("rst_show_an", an, 6'h3F);
    check("rst_show_neg", negative, 0);

    // Randomized traffic checked by the model.
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        clear = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          product_valid = 1'b1; product = WIDTH'($urandom);
        end
        @(negedge clk);
        clear = 1'b0; product_valid = 1'b0;
      end else if (r < 11) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if (r < 60) begin
        if ($urandom_range(0, 3) == 0) pulse(specials[$urandom_range(0, 9)]);
        else pulse(WIDTH'($urandom));
      end else begin
        cyc($urandom_range(1, 30));
      end
    end
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
